if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address and instruction width in bits.
REQ-002 SHALL have parameter DEPTH, fixed 4, meaning instruction buffer entries and maximum requests in flight.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rstn  input  1  synchronous reset, active low.
REQ-005 SHALL have port pc_i  input  AW  current PC from the PC register.
REQ-006 SHALL have port jump_flag  input  1  redirect/flush request, same signal that loads the PC register.
REQ-007 SHALL have port hold_o  output  1  hold request to the PC register; 1 = PC must not advance.
REQ-008 SHALL have port imem_req_valid  output  1  instruction-memory request valid.
REQ-009 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-010 SHALL have port imem_addr  output  AW  request address.
REQ-011 SHALL have port imem_rsp_valid  input  1  in-order response valid, no backpressure.
REQ-012 SHALL have port imem_rsp_data  input  AW  instruction word.
REQ-013 SHALL have port inst_valid_o  output  1  buffered instruction available to decode.
REQ-014 SHALL have port inst_o  output  AW  instruction at buffer head.
REQ-015 SHALL have port inst_pc_o  output  AW  PC of instruction at buffer head.
REQ-016 SHALL have port id_ready_i  input  1  decode consumes head this cycle.

Function
REQ-017 SHALL define req_fire = imem_req_valid & imem_req_ready, pop = inst_valid_o & id_ready_i.
REQ-018 SHALL drive imem_addr = pc_i combinationally.
REQ-019 SHALL assert imem_req_valid iff rstn=1, jump_flag=0, state=RUN, and (outstanding + buf_count) < DEPTH.
REQ-020 SHALL drive hold_o = ~req_fire; PC advances only on an accepted request (jump_flag overrides in PC register).
REQ-021 SHALL keep a 3-bit outstanding counter: +1 on req_fire, -1 on accepted response or dropped response, both same cycle = unchanged.
REQ-022 SHALL push pc_i into a DEPTH-entry PC tag queue on req_fire; pop tag on each response.
REQ-023 SHALL, in RUN, write {rsp_data, tag PC} into a DEPTH-entry instruction FIFO on imem_rsp_valid.
REQ-024 SHALL present FIFO head combinationally on inst_o/inst_pc_o; inst_valid_o = (buf_count != 0).
REQ-025 SHALL support simultaneous push and pop at any occupancy including full; count unchanged.
REQ-026 SHALL never overflow: credit rule REQ-019 guarantees a slot for every outstanding response.
REQ-027 SHALL use 2-bit wrapping read/write pointers and a 3-bit count (0..4).
REQ-028 SHALL implement FSM states RUN and DROP.
REQ-029 SHALL, on jump_flag=1 in any state: clear FIFO and tag queue, suppress req and pop that cycle, load drop_cnt = outstanding minus (1 if imem_rsp_valid that cycle), go to DROP if drop_cnt>0 else RUN.
REQ-030 SHALL, in DROP, discard each imem_rsp_valid and decrement drop_cnt; return to RUN on the cycle drop_cnt reaches 0; no requests issued in DROP.
REQ-031 SHALL, in DROP, keep hold_o=1 so the redirected PC is held until fetch resumes.
REQ-032 SHALL give zero-cycle latency from buffer to decode; minimum fetch latency is memory latency plus one cycle (registered FIFO write).
REQ-033 SHALL flag as an assertion: imem_rsp_valid while outstanding=0.

Reset
REQ-034 SHALL, when rstn=0 at a rising edge: state=RUN, outstanding=0, drop_cnt=0, buf_count=0, pointers=0.
REQ-035 SHALL, during reset, drive imem_req_valid=0, hold_o=1, inst_valid_o=0; inst_o/inst_pc_o=0.
REQ-036 SHALL discard responses arriving during reset or after reset of a mid-flight request.

Verification
REQ-037 Streaming: ready=1, 1-cycle memory, pc 0,4,8 -> inst_valid_o one cycle after each response, inst_pc_o 0,4,8 in order, hold_o=0 each fire cycle.
REQ-038 Backpressure: id_ready_i=0, ready=1 -> 4 requests then imem_req_valid=0, hold_o=1, buf_count=4; id_ready_i=1 one cycle -> one new request issued.
REQ-039 Flush: 2 outstanding, jump_flag pulse, pc_i=0x100 -> buffer empty, next 2 responses dropped, first delivered inst_pc_o=0x100.
REQ-040 Jump with coincident response: outstanding=1, rsp_valid and jump_flag same cycle -> state stays RUN, response not buffered.
REQ-041 Full with push+pop: buf_count=4, pop and response same cycle (outstanding prevented) -> assertion check that no push occurs when full; count stays 4 on pop+refill sequence.
REQ-042 Mid-operation reset: rstn=0 with 3 outstanding -> all counters 0, inst_valid_o=0 next cycle, late responses ignored.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch front end: issues credit-limited memory requests, tags them with their PC,
// and buffers in-order responses for decode; redirects flush and drop stale responses.
module if_fetch #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] pc_i,
  input  logic          jump_flag,
  output logic          hold_o,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rsp_valid,
  input  logic [AW-1:0] imem_rsp_data,
  output logic          inst_valid_o,
  output logic [AW-1:0] inst_o,
  output logic [AW-1:0] inst_pc_o,
  input  logic          id_ready_i
);

  localparam logic [2:0] Full   = 3'(DEPTH);
  localparam logic [3:0] Credit = 4'(DEPTH);

  typedef enum logic [0:0] {StRun, StDrop} state_e;

  state_e     state_q, state_d;
  logic [2:0] outst_q, outst_d;
  logic [2:0] drop_cnt_q, drop_cnt_d;
  logic [2:0] buf_cnt_q, buf_cnt_d;
  logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0] tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;

  logic [AW-1:0] inst_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];
  logic [AW-1:0] tag_mem  [DEPTH];

  logic       req_fire, pop, push, rsp_ok, run;
  logic [3:0] in_system;

  // Responses with nothing outstanding are stale (e.g. from before a reset) and are ignored.
  assign rsp_ok    = imem_rsp_valid & (outst_q != 3'd0);
  assign run       = (state_q == StRun);
  assign in_system = {1'b0, outst_q} + {1'b0, buf_cnt_q};

  assign imem_addr      = pc_i;
  assign imem_req_valid = rstn & ~jump_flag & run & (in_system < Credit);
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign hold_o         = ~req_fire;

  assign inst_valid_o = rstn & (buf_cnt_q != 3'd0);
  assign inst_o       = inst_valid_o ? inst_mem[rptr_q] : '0;
  assign inst_pc_o    = inst_valid_o ? pc_mem[rptr_q]   : '0;

  assign pop  = inst_valid_o & id_ready_i & ~jump_flag;
  assign push = rstn & ~jump_flag & run & rsp_ok;

  always_comb begin
    state_d    = state_q;
    outst_d    = outst_q + {2'b0, req_fire} - {2'b0, rsp_ok};
    drop_cnt_d = drop_cnt_q;
    buf_cnt_d  = buf_cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    tag_wptr_d = tag_wptr_q;
    tag_rptr_d = tag_rptr_q;

    if (jump_flag) begin
      // Everything in flight now belongs to the old path and must be discarded.
      buf_cnt_d  = 3'd0;
      wptr_d     = 2'd0;
      rptr_d     = 2'd0;
      tag_wptr_d = 2'd0;
      tag_rptr_d = 2'd0;
      drop_cnt_d = outst_q - {2'b0, rsp_ok};
      state_d    = (drop_cnt_d != 3'd0) ? StDrop : StRun;
    end else if (run) begin
      buf_cnt_d = buf_cnt_q + {2'b0, push} - {2'b0, pop};
      if (push) wptr_d = wptr_q + 2'd1;
      if (pop) rptr_d = rptr_q + 2'd1;
      if (req_fire) tag_wptr_d = tag_wptr_q + 2'd1;
      if (rsp_ok) tag_rptr_d = tag_rptr_q + 2'd1;
    end else begin
      buf_cnt_d = buf_cnt_q - {2'b0, pop};
      if (pop) rptr_d = rptr_q + 2'd1;
      if (rsp_ok && drop_cnt_q != 3'd0) begin
        drop_cnt_d = drop_cnt_q - 3'd1;
        if (drop_cnt_q == 3'd1) state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StRun;
      outst_q    <= 3'd0;
      drop_cnt_q <= 3'd0;
      buf_cnt_q  <= 3'd0;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      tag_wptr_q <= 2'd0;
      tag_rptr_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      outst_q    <= outst_d;
      drop_cnt_q <= drop_cnt_d;
      buf_cnt_q  <= buf_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      tag_wptr_q <= tag_wptr_d;
      tag_rptr_q <= tag_rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wptr_q] <= imem_rsp_data;
      pc_mem[wptr_q]   <= tag_mem[tag_rptr_q];
    end
    if (req_fire) tag_mem[tag_wptr_q] <= pc_i;
  end

`ifndef SYNTHESIS
  a_rsp_without_req: assert property (@(posedge clk) disable iff (!rstn)
    imem_rsp_valid |-> outst_q != 3'd0);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
    push |-> (buf_cnt_q != Full) || pop);
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: behavioural PC register and in-order memory model, with a
// scoreboard of expected {pc, instruction} pairs compared as decode consumes the buffer head.
module tb_if_fetch;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] pc_i;
  logic          jump_flag;
  logic          hold_o;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_addr;
  logic          imem_rsp_valid;
  logic [AW-1:0] imem_rsp_data;
  logic          inst_valid_o;
  logic [AW-1:0] inst_o;
  logic [AW-1:0] inst_pc_o;
  logic          id_ready_i;

  if_fetch #(.AW(AW), .DEPTH(4)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .pc_i           (pc_i),
    .jump_flag      (jump_flag),
    .hold_o         (hold_o),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid_o   (inst_valid_o),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .id_ready_i     (id_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
    int          ep;
  } mem_req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  mem_req_t    pipe[$];
  exp_t        exp_buf[$];
  logic [31:0] popped[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  int          jump_at = -1;
  int          n_fires = 0;
  int          n_pops = 0;
  logic [31:0] jump_target = '0;
  logic [31:0] pc_model = '0;
  logic        ready_drv = 1'b1;
  logic        idr_drv = 1'b1;
  logic        rstn_drv = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h1357_9bdf;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, sample #1 later, then advance the models.
  task automatic tick();
    logic        stale, exp_rv, fire, rsp, jmp;
    mem_req_t    r;
    exp_t        e;
    @(negedge clk);
    cyc++;
    jmp            = (cyc == jump_at);
    rstn           = rstn_drv;
    jump_flag      = jmp;
    pc_i           = pc_model;
    imem_req_ready = ready_drv;
    id_ready_i     = idr_drv;
    rsp            = (pipe.size() != 0) && (pipe[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pipe[0].addr) : '0;
    #1;
    stale = 1'b0;
    foreach (pipe[i]) if (pipe[i].ep != epoch) stale = 1'b1;
    exp_rv = rstn_drv && !jmp && !stale && (pipe.size() + exp_buf.size() < 4);
    fire   = exp_rv && ready_drv;
    check_eq("req_valid", imem_req_valid, exp_rv);
    check_eq("hold", hold_o, !fire);
    check_eq("inst_valid", inst_valid_o, rstn_drv && exp_buf.size() != 0);
    if (exp_rv) check_eq("addr", imem_addr, pc_model);
    if (!rstn_drv) begin
      check_eq("rst_inst", inst_o, 32'h0);
      check_eq("rst_inst_pc", inst_pc_o, 32'h0);
    end
    if (rstn_drv && !jmp && idr_drv && exp_buf.size() != 0) begin
      e = exp_buf.pop_front();
      check_eq("inst_pc", inst_pc_o, e.pc);
      check_eq("inst", inst_o, e.inst);
      popped.push_back(inst_pc_o);
      n_pops++;
    end
    if (rsp) begin
      r = pipe.pop_front();
      if (rstn_drv && !jmp && r.ep == epoch) exp_buf.push_back('{pc: r.addr, inst: mem_word(r.addr)});
    end
    if (fire) begin
      pipe.push_back('{due: cyc + lat, addr: pc_model, ep: epoch});
      n_fires++;
    end
    if (!rstn_drv || jmp) begin
      exp_buf.delete();
      epoch++;
    end
    if (!rstn_drv) pc_model = '0;
    else if (jmp) pc_model = jump_target;
    else if (fire) pc_model = pc_model + 32'd4;
  endtask

  task automatic drain();
    ready_drv = 1'b0;
    idr_drv   = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    int f0, p0, c0;
    rstn = 1'b0; jump_flag = 1'b0; pc_i = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready_i = 1'b0;
    repeat (3) tick();
    rstn_drv = 1'b1;

    // Streaming with a 1-cycle memory.
    popped.delete();
    repeat (12) tick();
    check_eq("stream_count", popped.size() >= 3, 1);
    if (popped.size() >= 3) begin
      check_eq("stream_pc0", popped[0], 32'h0);
      check_eq("stream_pc1", popped[1], 32'h4);
      check_eq("stream_pc2", popped[2], 32'h8);
    end

    // Backpressure: buffer fills to four, then one pop frees exactly one credit.
    drain();
    idr_drv = 1'b0; ready_drv = 1'b1; f0 = n_fires;
    repeat (10) tick();
    check_eq("bp_fires", n_fires - f0, 4);
    check_eq("bp_full_valid", inst_valid_o, 1);
    idr_drv = 1'b1; p0 = n_pops;
    tick();
    idr_drv = 1'b0; f0 = n_fires;
    repeat (6) tick();
    check_eq("bp_one_pop", n_pops - p0, 1);
    check_eq("bp_one_refill", n_fires - f0, 1);
    check_eq("bp_refilled_valid", inst_valid_o, 1);

    // Flush with two outstanding requests.
    drain();
    lat = 4; ready_drv = 1'b1; idr_drv = 1'b0;
    repeat (2) tick();
    check_eq("flush_setup", pipe.size(), 2);
    jump_target = 32'h100; jump_at = cyc + 1;
    tick();
    check_eq("flush_empty", inst_valid_o, 0);
    popped.delete(); idr_drv = 1'b1;
    repeat (16) tick();
    check_eq("flush_count", popped.size() >= 2, 1);
    if (popped.size() >= 2) begin
      check_eq("flush_pc0", popped[0], 32'h100);
      check_eq("flush_pc1", popped[1], 32'h104);
    end

    // Jump coinciding with the only outstanding response.
    drain();
    lat = 2; ready_drv = 1'b1;
    tick();
    c0 = cyc; ready_drv = 1'b0;
    jump_target = 32'h200; jump_at = c0 + 2;
    repeat (2) tick();
    tick();
    check_eq("jrsp_run", imem_req_valid, 1);
    check_eq("jrsp_not_buffered", inst_valid_o, 0);
    popped.delete(); ready_drv = 1'b1;
    repeat (10) tick();
    check_eq("jrsp_count", popped.size() >= 1, 1);
    if (popped.size() >= 1) check_eq("jrsp_pc0", popped[0], 32'h200);

    // Reset with three requests in flight; their responses arrive during reset.
    drain();
    lat = 3; idr_drv = 1'b0; ready_drv = 1'b1;
    repeat (3) tick();
    check_eq("rst_setup", pipe.size(), 3);
    rstn_drv = 1'b0;
    repeat (5) tick();
    rstn_drv = 1'b1;
    tick();
    check_eq("rst_no_valid", inst_valid_o, 0);
    popped.delete(); idr_drv = 1'b1;
    repeat (12) tick();
    check_eq("rst_count", popped.size() >= 1, 1);
    if (popped.size() >= 1) check_eq("rst_pc0", popped[0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
